// File: rtl/round_countdown.sv
// Round countdown sequencer: programs an interval timer, counts one tick per timer irq,
// and reports completion; every output is registered off the next-state decode.
module round_countdown #(
  parameter logic [31:0] PERIOD = 32'd49999999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  seconds_in,
  input  logic        timer_irq,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  output logic [7:0]  seconds_left,
  output logic        running,
  output logic        tick,
  output logic        round_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_PL   = 3'd1,
    WR_PH   = 3'd2,
    WR_CTRL = 3'd3,
    RUN     = 3'd4,
    CLR     = 3'd5,
    STOP    = 3'd6
  } state_t;

  localparam logic [2:0]  ADDR_STATUS = 3'd0;
  localparam logic [2:0]  ADDR_CTRL   = 3'd1;
  localparam logic [2:0]  ADDR_PL     = 3'd2;
  localparam logic [2:0]  ADDR_PH     = 3'd3;
  localparam logic [15:0] CTRL_GO     = 16'h0007;
  localparam logic [15:0] CTRL_STOP   = 16'h0008;

  state_t      state_q, state_d;
  logic [7:0]  left_q, left_d;
  logic        done_pend_q, done_pend_d;
  logic        tick_q, tick_d;
  logic        done_q, done_d;
  logic        running_q, running_d;
  logic        cs_q, cs_d;
  logic        wn_q, wn_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;

  // Next-state, counter and completion bookkeeping.
  always_comb begin
    state_d     = state_q;
    left_d      = left_q;
    done_pend_d = done_pend_q;
    tick_d      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (seconds_in != 8'd0) begin
            left_d      = seconds_in;
            done_pend_d = 1'b0;
            state_d     = WR_PL;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      WR_PL:   state_d = abort ? STOP : WR_PH;
      WR_PH:   state_d = abort ? STOP : WR_CTRL;
      WR_CTRL: state_d = abort ? STOP : RUN;
      RUN: begin
        if (abort) begin
          state_d = STOP;
        end else if (timer_irq) begin
          tick_d  = 1'b1;
          left_d  = (left_q != 8'd0) ? (left_q - 8'd1) : 8'd0;
          state_d = CLR;
        end
      end
      CLR: begin
        // The status clear is on the bus this cycle, so the irq that caused it
        // is gone before RUN samples timer_irq again.
        if (abort) begin
          state_d = STOP;
        end else if (left_q != 8'd0) begin
          state_d = RUN;
        end else begin
          done_pend_d = 1'b1;
          state_d     = STOP;
        end
      end
      STOP: begin
        done_d      = done_pend_q;
        done_pend_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus and status outputs follow the state being entered.
  always_comb begin
    cs_d      = 1'b0;
    wn_d      = 1'b1;
    addr_d    = 3'd0;
    data_d    = 16'd0;
    running_d = (state_d != IDLE);
    case (state_d)
      WR_PL: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PL; data_d = PERIOD[15:0];
      end
      WR_PH: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PH; data_d = PERIOD[31:16];
      end
      WR_CTRL: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_CTRL; data_d = CTRL_GO;
      end
      CLR: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_STATUS; data_d = 16'd0;
      end
      STOP: begin
        cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_CTRL; data_d = CTRL_STOP;
      end
      default: begin
        cs_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      left_q      <= 8'd0;
      done_pend_q <= 1'b0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
      running_q   <= 1'b0;
      cs_q        <= 1'b0;
      wn_q        <= 1'b1;
      addr_q      <= 3'd0;
      data_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      left_q      <= left_d;
      done_pend_q <= done_pend_d;
      tick_q      <= tick_d;
      done_q      <= done_d;
      running_q   <= running_d;
      cs_q        <= cs_d;
      wn_q        <= wn_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign tmr_address    = addr_q;
  assign tmr_chipselect = cs_q;
  assign tmr_write_n    = wn_q;
  assign tmr_writedata  = data_q;
  assign seconds_left   = left_q;
  assign running        = running_q;
  assign tick           = tick_q;
  assign round_done     = done_q;

endmodule

// File: tb/tb_round_countdown.sv
// Scoreboard bench for round_countdown: stimulus pushes expected bus writes, ticks and
// completions; a negedge monitor pops and compares whenever the DUT presents one.
module tb_round_countdown;
  localparam logic [31:0] P = 32'd9;

  logic        clk = 1'b0;
  logic        reset, start, abort, timer_irq;
  logic [7:0]  seconds_in;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect, tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [7:0]  seconds_left;
  logic        running, tick, round_done;

  round_countdown #(.PERIOD(P)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .seconds_in(seconds_in), .timer_irq(timer_irq),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .seconds_left(seconds_left), .running(running), .tick(tick),
    .round_done(round_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] tq[$];
  int         dq[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_left = 8'd0;
  logic       mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every presented event must match the head of its queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (tmr_chipselect) begin
        vectors++;
        if (wq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: got addr %0d data %0h expected none", tmr_address, tmr_writedata);
        end else begin
          wr_t w;
          w = wq.pop_front();
          if (tmr_address !== w.a || tmr_writedata !== w.d || tmr_write_n !== 1'b0) begin
            miscompares++;
            $display("FAIL bus_write: got addr %0d data %0h wn %b expected addr %0d data %0h wn 0",
                     tmr_address, tmr_writedata, tmr_write_n, w.a, w.d);
          end
        end
      end else begin
        vectors++;
        if (tmr_write_n !== 1'b1 || tmr_address !== 3'd0 || tmr_writedata !== 16'd0) begin
          miscompares++;
          $display("FAIL idle_bus: got wn %b addr %0d data %0h expected 1 0 0",
                   tmr_write_n, tmr_address, tmr_writedata);
        end
      end
      if (tick) begin
        vectors++;
        if (tq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_tick: got tick with left %0d expected none", seconds_left);
        end else begin
          logic [7:0] e;
          e = tq.pop_front();
          if (seconds_left !== e) begin
            miscompares++;
            $display("FAIL tick_left: got %0d expected %0d", seconds_left, e);
          end
        end
      end
      if (round_done) begin
        vectors++;
        if (dq.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done: got round_done expected none");
        end else begin
          void'(dq.pop_front());
        end
      end
    end
  end

  task automatic start_round(input logic [7:0] n);
    wq.push_back({3'd2, P[15:0]});
    wq.push_back({3'd3, P[31:16]});
    wq.push_back({3'd1, 16'h0007});
    exp_left   = n;
    seconds_in = n;
    start      = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("start_running", {31'd0, running}, 32'd1);
    chk("start_left", {24'd0, seconds_left}, {24'd0, n});
    chk("wr_pl_addr", {29'd0, tmr_address}, 32'd2);
    cyc(1);
    chk("wr_ph_addr", {29'd0, tmr_address}, 32'd3);
    cyc(1);
    chk("wr_ctrl_data", {16'd0, tmr_writedata}, 32'h0007);
    cyc(1);
    chk("run_no_write", {31'd0, tmr_chipselect}, 32'd0);
  endtask

  task automatic irq_step();
    bit got;
    exp_left = exp_left - 8'd1;
    tq.push_back(exp_left);
    wq.push_back({3'd0, 16'h0000});
    if (exp_left == 8'd0) begin
      wq.push_back({3'd1, 16'h0008});
      dq.push_back(1);
    end
    timer_irq = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (tmr_chipselect && tmr_address == 3'd0) begin
        got = 1'b1;
        break;
      end
    end
    timer_irq = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL clr_timeout: got no status clear expected one within 20 cycles");
    end
    if (exp_left == 8'd0) begin
      cyc(2);
      chk("done_pulse", {31'd0, round_done}, 32'd1);
      chk("done_running", {31'd0, running}, 32'd0);
    end else begin
      cyc(1);
    end
  endtask

  task automatic do_abort(input logic with_irq);
    wq.push_back({3'd1, 16'h0008});
    abort     = 1'b1;
    timer_irq = with_irq;
    cyc(1);
    abort     = 1'b0;
    timer_irq = 1'b0;
    chk("abort_no_tick", {31'd0, tick}, 32'd0);
    chk("abort_left", {24'd0, seconds_left}, {24'd0, exp_left});
    chk("abort_stop_data", {16'd0, tmr_writedata}, 32'h0008);
    cyc(1);
    chk("abort_idle", {31'd0, running}, 32'd0);
    chk("abort_no_done", {31'd0, round_done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; timer_irq = 1'b0; seconds_in = 8'd0;
    cyc(3);
    chk("rst_left", {24'd0, seconds_left}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_cs", {31'd0, tmr_chipselect}, 32'd0);
    chk("rst_wn", {31'd0, tmr_write_n}, 32'd1);
    reset  = 1'b0;
    mon_en = 1'b1;
    cyc(2);

    // Full three-tick round.
    start_round(8'd3);
    irq_step();
    irq_step();
    irq_step();
    cyc(2);
    chk("final_left", {24'd0, seconds_left}, 32'd0);

    // Zero-length round: done next cycle, no writes.
    dq.push_back(1);
    seconds_in = 8'd0;
    start      = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("zero_done", {31'd0, round_done}, 32'd1);
    chk("zero_running", {31'd0, running}, 32'd0);
    cyc(1);
    chk("zero_done_once", {31'd0, round_done}, 32'd0);

    // Abort colliding with irq at 5.
    start_round(8'd5);
    do_abort(1'b1);
    cyc(2);
    chk("abort_retained", {24'd0, seconds_left}, 32'd5);

    // Start while running is ignored.
    start_round(8'd4);
    irq_step();
    seconds_in = 8'd9;
    start      = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("restart_left", {24'd0, seconds_left}, 32'd3);
    chk("restart_running", {31'd0, running}, 32'd1);
    do_abort(1'b0);

    // Randomised rounds with occasional aborts.
    for (int r = 0; r < 12; r++) begin
      start_round(8'($urandom_range(1, 6)));
      while (exp_left != 8'd0) begin
        cyc($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) begin
          do_abort(1'($urandom_range(0, 1)));
          break;
        end
        irq_step();
      end
      cyc(2);
      chk("rand_left", {24'd0, seconds_left}, {24'd0, exp_left});
    end

    // Reset during the PERIOD high write.
    wq.push_back({3'd2, P[15:0]});
    wq.push_back({3'd3, P[31:16]});
    seconds_in = 8'd2;
    start      = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    chk("pre_rst_addr", {29'd0, tmr_address}, 32'd3);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("midrst_cs", {31'd0, tmr_chipselect}, 32'd0);
    chk("midrst_wn", {31'd0, tmr_write_n}, 32'd1);
    chk("midrst_data", {16'd0, tmr_writedata}, 32'd0);
    chk("midrst_left", {24'd0, seconds_left}, 32'd0);
    chk("midrst_running", {31'd0, running}, 32'd0);
    cyc(6);
    chk("post_rst_running", {31'd0, running}, 32'd0);

    cyc(2);
    chk("wq_drained", wq.size(), 32'd0);
    chk("tq_drained", tq.size(), 32'd0);
    chk("dq_drained", dq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
